// File: rtl/kv_hash_table.sv
// Request FIFO feeding a direct-mapped key table with LOOKUP/INSERT/DELETE, one in-order response per accepted request.
// Optional KV_STATS_EN builds the saturating hit/miss/drop counters; otherwise those ports read zero.
module kv_hash_table #(
    parameter int KEY_SIZE = 96,
    parameter int IDX_BITS = 10,
    parameter int FIFO_AW  = 3
) (
    input  logic                clk156,
    input  logic                eth_rst,
    input  logic [KEY_SIZE-1:0] in_key,
    input  logic [3:0]          in_flag,
    input  logic                in_valid,
    output logic                out_valid,
    output logic [3:0]          out_flag,
    output logic                init_done,
    output logic [31:0]         hit_cnt,
    output logic [31:0]         miss_cnt,
    output logic [31:0]         drop_cnt
);
    localparam int NCHUNK = (KEY_SIZE + IDX_BITS - 1) / IDX_BITS;
    localparam logic [3:0] OP_LOOKUP = 4'b0001;
    localparam logic [3:0] OP_INSERT = 4'b0010;
    localparam logic [3:0] OP_DELETE = 4'b0100;

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_READ, S_CMP, S_RESP} state_t;
    state_t state, next_state;

    // Key is zero-padded up to a whole number of chunks before folding.
    function automatic logic [IDX_BITS-1:0] fold_key(input logic [KEY_SIZE-1:0] k);
        logic [NCHUNK*IDX_BITS-1:0] padded;
        logic [IDX_BITS-1:0]        acc;
        padded = '0;
        padded[KEY_SIZE-1:0] = k;
        acc = '0;
        for (int i = 0; i < NCHUNK; i++) acc = acc ^ padded[i*IDX_BITS +: IDX_BITS];
        return acc;
    endfunction

    logic [KEY_SIZE+3:0]  fifo_mem [2**FIFO_AW];
    logic [FIFO_AW:0]     wr_ptr, rd_ptr;
    logic                 full, empty, push, pop;
    logic [KEY_SIZE-1:0]  head_key;
    logic [3:0]           head_flag;

    logic [KEY_SIZE:0]    tbl [2**IDX_BITS];
    logic [KEY_SIZE:0]    rd_data;
    logic                 tbl_we;
    logic [IDX_BITS-1:0]  tbl_waddr;
    logic [KEY_SIZE:0]    tbl_wdata;

    logic [KEY_SIZE-1:0]  req_key;
    logic [3:0]           req_flag;
    logic [IDX_BITS-1:0]  req_idx;
    logic [IDX_BITS-1:0]  init_addr;
    logic [3:0]           resp_flag, cmp_flag;
    logic                 hit;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                       (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign push      = in_valid && !full;
    assign head_key  = fifo_mem[rd_ptr[FIFO_AW-1:0]][KEY_SIZE+3:4];
    assign head_flag = fifo_mem[rd_ptr[FIFO_AW-1:0]][3:0];
    assign hit       = rd_data[KEY_SIZE] && (rd_data[KEY_SIZE-1:0] == req_key);

    always_ff @(posedge clk156) begin
        if (eth_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk156) begin
        if (push) fifo_mem[wr_ptr[FIFO_AW-1:0]] <= {in_key, in_flag};
    end

    // INIT and CMP are the only writers and never overlap a read, so one port pair suffices.
    always_ff @(posedge clk156) begin
        if (tbl_we) tbl[tbl_waddr] <= tbl_wdata;
        if (pop)    rd_data <= tbl[fold_key(head_key)];
    end

    always_ff @(posedge clk156) begin
        if (pop) begin
            req_key  <= head_key;
            req_flag <= head_flag;
            req_idx  <= fold_key(head_key);
        end
    end

    always_ff @(posedge clk156) begin
        if (eth_rst) state <= S_INIT;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        tbl_we     = 1'b0;
        tbl_waddr  = init_addr;
        tbl_wdata  = '0;
        cmp_flag   = 4'b1000;
        case (state)
            S_INIT: begin
                tbl_we = 1'b1;
                if (init_addr == '1) next_state = S_IDLE;
            end
            S_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    next_state = S_READ;
                end
            end
            S_READ: next_state = S_CMP;
            S_CMP: begin
                tbl_waddr  = req_idx;
                next_state = S_RESP;
                case (req_flag)
                    OP_LOOKUP: cmp_flag = hit ? 4'b0001 : 4'b0010;
                    OP_INSERT: begin
                        if (hit) begin
                            cmp_flag = 4'b0001;
                        end else begin
                            cmp_flag  = 4'b0110;
                            tbl_we    = 1'b1;
                            tbl_wdata = {1'b1, req_key};
                        end
                    end
                    OP_DELETE: begin
                        if (hit) begin
                            cmp_flag = 4'b0101;
                            tbl_we   = 1'b1;
                        end else begin
                            cmp_flag = 4'b0010;
                        end
                    end
                    default: cmp_flag = 4'b1000;
                endcase
            end
            S_RESP:  next_state = S_IDLE;
            default: next_state = S_INIT;
        endcase
    end

    always_ff @(posedge clk156) begin
        if (eth_rst) begin
            init_addr <= '0;
            init_done <= 1'b0;
        end else if (state == S_INIT) begin
            init_addr <= init_addr + 1'b1;
            if (init_addr == '1) init_done <= 1'b1;
        end
    end

    always_ff @(posedge clk156) begin
        if (eth_rst)            resp_flag <= 4'd0;
        else if (state == S_CMP) resp_flag <= cmp_flag;
    end

    assign out_valid = (state == S_RESP);
    assign out_flag  = (state == S_RESP) ? resp_flag : 4'd0;

`ifdef KV_STATS_EN
    logic drop;
    assign drop = in_valid && full;

    always_ff @(posedge clk156) begin
        if (eth_rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (state == S_RESP && resp_flag[0] && hit_cnt != '1)  hit_cnt  <= hit_cnt + 32'd1;
            if (state == S_RESP && resp_flag[1] && miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
            if (drop && drop_cnt != '1)                            drop_cnt <= drop_cnt + 32'd1;
        end
    end
`else
    assign hit_cnt  = 32'd0;
    assign miss_cnt = 32'd0;
    assign drop_cnt = 32'd0;
`endif
endmodule
